// File: rtl/cmd_encoder.sv
// Serialises one layer command per valid/ready handshake into six 32-bit command-FIFO words.
// Latency: handshake at edge N -> words in cycles N+1..N+6, ready again N+7; stalls while fifo_full.
module cmd_encoder #(
    parameter int MAX_CMDS  = 127,
    parameter int CMD_WORDS = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_op_type,
    input  logic        i_padding,
    input  logic [7:0]  i_stride_1,
    input  logic [15:0] i_stride_2,
    input  logic [15:0] i_ich_size,
    input  logic [15:0] i_och_size,
    input  logic [15:0] i_ikn_size,
    input  logic [15:0] i_okn_size,
    input  logic [31:0] i_weight_start_addr,
    input  logic [31:0] i_data_start_addr,
    input  logic [31:0] i_wb_addr,
    output logic [31:0] o_fifo_din,
    output logic        o_fifo_wr_en,
    input  logic        i_fifo_full,
    input  logic        i_clear,
    output logic [6:0]  o_cmd_size,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [6:0] MAX_SIZE = 7'(MAX_CMDS);
    localparam logic [2:0] LAST_IDX = 3'(CMD_WORDS - 1);

    state_t      r_state;
    logic [2:0]  r_word_idx;
    logic [6:0]  r_cmd_size;
    logic        r_err;
    logic [31:0] r_w0;
    logic [31:0] r_w1;
    logic [31:0] r_w2;
    logic [31:0] r_w3;
    logic [31:0] r_w4;
    logic [31:0] r_w5;

    logic        w_idle;
    logic        w_accept;
    logic        w_legal;
    logic        w_wr;
    logic [31:0] w_word;

    assign w_idle      = (r_state == S_IDLE);
    assign o_cmd_ready = w_idle && (r_cmd_size < MAX_SIZE) && !i_clear;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_legal     = (i_op_type >= 3'd1) && (i_op_type <= 3'd5);

    // Write strobe follows fifo_full combinationally so a stalled word is never written twice.
    assign w_wr         = (r_state == S_EMIT) && !i_fifo_full;
    assign o_fifo_wr_en = w_wr;
    assign o_busy       = (r_state == S_EMIT);
    assign o_cmd_size   = r_cmd_size;
    assign o_err        = r_err;

    always_comb begin
        w_word = '0;
        case (r_word_idx)
            3'd0:    w_word = r_w0;
            3'd1:    w_word = r_w1;
            3'd2:    w_word = r_w2;
            3'd3:    w_word = r_w3;
            3'd4:    w_word = r_w4;
            3'd5:    w_word = r_w5;
            default: w_word = '0;
        endcase
    end

    assign o_fifo_din = o_busy ? w_word : '0;

    // Fields are packed at capture so the emit path is a plain word select.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_w0 <= {i_stride_2, i_stride_1, 4'b0000, i_padding, i_op_type};
            r_w1 <= {i_och_size, i_ich_size};
            r_w2 <= {i_okn_size, i_ikn_size};
            r_w3 <= i_weight_start_addr;
            r_w4 <= i_data_start_addr;
            r_w5 <= i_wb_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_word_idx <= '0;
            r_cmd_size <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_clear) begin
                        r_cmd_size <= '0;
                        r_err      <= 1'b0;
                    end else if (w_accept) begin
                        if (w_legal) begin
                            r_state    <= S_EMIT;
                            r_word_idx <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_wr) begin
                        if (r_word_idx == LAST_IDX) begin
                            r_word_idx <= '0;
                            r_state    <= S_IDLE;
                            if (r_cmd_size < MAX_SIZE) begin
                                r_cmd_size <= r_cmd_size + 7'd1;
                            end
                        end else begin
                            r_word_idx <= r_word_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_word_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_encoder.sv
// Self-checking bench for cmd_encoder: table vectors, hand-written corner sequences, randomized model check.
module tb_cmd_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [2:0]  op_type;
    logic        padding;
    logic [7:0]  stride_1;
    logic [15:0] stride_2, ich_size, och_size, ikn_size, okn_size;
    logic [31:0] weight_start_addr, data_start_addr, wb_addr;
    logic        fifo_full;
    logic        clear;

    logic        d1_ready, d1_wr_en, d1_busy, d1_err;
    logic [31:0] d1_din;
    logic [6:0]  d1_size;
    logic        d2_ready, d2_wr_en, d2_busy, d2_err;
    logic [31:0] d2_din;
    logic [6:0]  d2_size;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_size;
    logic exp_err;

    always #5 clk = ~clk;

    cmd_encoder #(.MAX_CMDS(127), .CMD_WORDS(6)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(d1_ready),
        .i_op_type(op_type), .i_padding(padding), .i_stride_1(stride_1), .i_stride_2(stride_2),
        .i_ich_size(ich_size), .i_och_size(och_size), .i_ikn_size(ikn_size), .i_okn_size(okn_size),
        .i_weight_start_addr(weight_start_addr), .i_data_start_addr(data_start_addr),
        .i_wb_addr(wb_addr), .o_fifo_din(d1_din), .o_fifo_wr_en(d1_wr_en), .i_fifo_full(fifo_full),
        .i_clear(clear), .o_cmd_size(d1_size), .o_busy(d1_busy), .o_err(d1_err)
    );

    cmd_encoder #(.MAX_CMDS(2), .CMD_WORDS(6)) u_dut_small (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(d2_ready),
        .i_op_type(op_type), .i_padding(padding), .i_stride_1(stride_1), .i_stride_2(stride_2),
        .i_ich_size(ich_size), .i_och_size(och_size), .i_ikn_size(ikn_size), .i_okn_size(okn_size),
        .i_weight_start_addr(weight_start_addr), .i_data_start_addr(data_start_addr),
        .i_wb_addr(wb_addr), .o_fifo_din(d2_din), .o_fifo_wr_en(d2_wr_en), .i_fifo_full(fifo_full),
        .i_clear(clear), .o_cmd_size(d2_size), .o_busy(d2_busy), .o_err(d2_err)
    );

    typedef struct {
        logic [2:0]       op;
        logic             pad;
        logic [7:0]       s1;
        logic [15:0]      s2, ich, och, ikn, okn;
        logic [31:0]      wsa, dsa, wba;
        logic             legal;
        logic [5:0][31:0] w;
    } vec_t;

    vec_t tbl[8];

    function automatic vec_t mkv(input logic [2:0] op, input logic pad, input logic [7:0] s1,
                                 input logic [15:0] s2, ich, och, ikn, okn,
                                 input logic [31:0] wsa, dsa, wba, input logic legal,
                                 input logic [31:0] e0, e1, e2, e3, e4, e5);
        vec_t v;
        v.op = op; v.pad = pad; v.s1 = s1; v.s2 = s2;
        v.ich = ich; v.och = och; v.ikn = ikn; v.okn = okn;
        v.wsa = wsa; v.dsa = dsa; v.wba = wba; v.legal = legal;
        v.w[0] = e0; v.w[1] = e1; v.w[2] = e2; v.w[3] = e3; v.w[4] = e4; v.w[5] = e5;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        op_type = v.op; padding = v.pad; stride_1 = v.s1; stride_2 = v.s2;
        ich_size = v.ich; och_size = v.och; ikn_size = v.ikn; okn_size = v.okn;
        weight_start_addr = v.wsa; data_start_addr = v.dsa; wb_addr = v.wba;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; fifo_full = 1'b0; clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_size = 0;
        exp_err  = 1'b0;
    endtask

    // Presents one command for one handshake and checks the whole resulting word stream on u_dut.
    task automatic send_check(input int i);
        @(negedge clk);
        drive(tbl[i]);
        cmd_valid = 1'b1;
        #1;
        chk("tbl_ready_before", d1_ready, 1'b1);
        if (tbl[i].legal) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                #1;
                chk("tbl_wr_en", d1_wr_en, 1'b1);
                chk($sformatf("tbl%0d_word%0d", i, k), d1_din, tbl[i].w[k]);
            end
            if (exp_size < 127) exp_size++;
        end else begin
            exp_err = 1'b1;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("tbl_wr_en_after", d1_wr_en, 1'b0);
        chk("tbl_busy_after", d1_busy, 1'b0);
        chk("tbl_ready_after", d1_ready, 1'b1);
        chk("tbl_cmd_size", d1_size, 32'(exp_size));
        chk("tbl_err", d1_err, exp_err);
    endtask

    logic [31:0] m_q[$];
    int          m_size;
    logic        m_err;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, writes;
        logic exp_busy, exp_ready, exp_wr;
        logic [31:0] w0;

        tbl[0] = mkv(3'd2, 1'b1, 8'd56, 16'd3136, 16'd64, 16'd16, 16'd3, 16'd1,
                     32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 1'b1,
                     32'h0C40380A, 32'h00100040, 32'h00010003,
                     32'h1000_0000, 32'h2000_0000, 32'h3000_0000);
        tbl[1] = mkv(3'd5, 1'b0, 8'hFF, 16'hFFFF, 16'hAAAA, 16'h5555, 16'h1234, 16'hABCD,
                     32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 1'b1,
                     32'hFFFFFF05, 32'h5555AAAA, 32'hABCD1234,
                     32'hDEADBEEF, 32'h0, 32'hFFFFFFFF);
        tbl[2] = mkv(3'd1, 1'b1, 8'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6,
                     32'd7, 32'd8, 32'd9, 1'b1,
                     32'h00020109, 32'h00040003, 32'h00060005, 32'd7, 32'd8, 32'd9);
        tbl[3] = mkv(3'd7, 1'b0, 8'h11, 16'h2222, 16'h3, 16'h4, 16'h5, 16'h6,
                     32'h1, 32'h2, 32'h3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tbl[4] = mkv(3'd3, 1'b0, 8'h10, 16'h0100, 16'h1, 16'h2, 16'h0, 16'h0,
                     32'h11111111, 32'h22222222, 32'h33333333, 1'b1,
                     32'h01001003, 32'h00020001, 32'h00000000,
                     32'h11111111, 32'h22222222, 32'h33333333);
        tbl[5] = mkv(3'd0, 1'b1, 8'h01, 16'h0001, 16'h1, 16'h1, 16'h1, 16'h1,
                     32'h1, 32'h1, 32'h1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tbl[6] = mkv(3'd4, 1'b1, 8'h80, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF,
                     32'hCAFEBABE, 32'h0BADF00D, 32'h12345678, 1'b1,
                     32'h8000800C, 32'h0000FFFF, 32'hFFFF0000,
                     32'hCAFEBABE, 32'h0BADF00D, 32'h12345678);
        tbl[7] = mkv(3'd6, 1'b1, 8'h55, 16'h6666, 16'h7, 16'h8, 16'h9, 16'hA,
                     32'hB, 32'hC, 32'hD, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        rst = 1'b1; cmd_valid = 1'b0; fifo_full = 1'b0; clear = 1'b0;
        drive(tbl[0]);

        // Reset state
        do_reset();
        chk("rst_wr_en", d1_wr_en, 1'b0);
        chk("rst_busy", d1_busy, 1'b0);
        chk("rst_din", d1_din, 32'h0);
        chk("rst_size", d1_size, 7'd0);
        chk("rst_err", d1_err, 1'b0);
        chk("rst_ready", d1_ready, 1'b1);

        // Table vectors, including illegal op_types
        for (int i = 0; i < 8; i++) send_check(i);

        // Clear drops ready that cycle, then zeroes size and err
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("clear_ready_low", d1_ready, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clear_err", d1_err, 1'b0);
        chk("clear_size", d1_size, 7'd0);
        chk("clear_ready", d1_ready, 1'b1);

        // Backpressure: full for 3 cycles while w2 pending
        do_reset();
        @(negedge clk);
        drive(tbl[0]);
        cmd_valid = 1'b1;
        nw = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            fifo_full = (c >= 2 && c <= 4);
            #1;
            if (fifo_full) begin
                chk("stall_wr_en", d1_wr_en, 1'b0);
                chk("stall_din_hold", d1_din, tbl[0].w[2]);
            end else begin
                chk("stall_wr_en_on", d1_wr_en, 1'b1);
                chk($sformatf("stall_word%0d", nw), d1_din, tbl[0].w[nw]);
                nw++;
            end
        end
        @(negedge clk);
        fifo_full = 1'b0;
        #1;
        chk("stall_done_busy", d1_busy, 1'b0);
        chk("stall_done_size", d1_size, 7'd1);

        // Saturation with MAX_CMDS=2 on the small instance
        do_reset();
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            drive(tbl[2]);
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int k = 0; k < 6; k++) @(negedge clk);
        end
        #1;
        chk("sat_size", d2_size, 7'd2);
        chk("sat_ready", d2_ready, 1'b0);
        drive(tbl[6]);
        cmd_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("sat_no_write", d2_wr_en, 1'b0);
            chk("sat_ready_held", d2_ready, 1'b0);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("sat_clear_size", d2_size, 7'd0);
        chk("sat_clear_ready", d2_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("sat_third_wr", d2_wr_en, 1'b1);
        chk("sat_third_w0", d2_din, tbl[6].w[0]);

        // Reset in the middle of a command
        do_reset();
        send_check(1);
        @(negedge clk);
        drive(tbl[4]);
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            chk("midrst_word", d1_din, tbl[4].w[k]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_wr_en", d1_wr_en, 1'b0);
        chk("midrst_size", d1_size, 7'd0);
        chk("midrst_busy", d1_busy, 1'b0);
        chk("midrst_ready", d1_ready, 1'b1);

        // Back-to-back: valid held for 4 commands, 24 writes in 28 cycles
        do_reset();
        @(negedge clk);
        drive(tbl[6]);
        cmd_valid = 1'b1;
        writes = 0;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            if (c == 27) cmd_valid = 1'b0;
            #1;
            if (d1_wr_en) begin
                chk("b2b_word", d1_din, tbl[6].w[writes % 6]);
                writes++;
            end
        end
        chk("b2b_writes", 32'(writes), 32'd24);
        chk("b2b_size", d1_size, 7'd4);
        chk("b2b_err", d1_err, 1'b0);
        chk("b2b_idle", d1_busy, 1'b0);

        // Randomized run against a queue-based model of the word stream
        do_reset();
        m_q.delete();
        m_size = 0;
        m_err  = 1'b0;
        for (int c = 0; c < 3500; c++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(1, 0) == 1);
            fifo_full = ($urandom_range(3, 0) == 0);
            clear     = (c >= 2500) && ($urandom_range(49, 0) == 0);
            op_type   = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'($urandom_range(5, 1));
            padding   = 1'($urandom);
            stride_1  = 8'($urandom);
            stride_2  = 16'($urandom);
            ich_size  = 16'($urandom);
            och_size  = 16'($urandom);
            ikn_size  = 16'($urandom);
            okn_size  = 16'($urandom);
            weight_start_addr = $urandom;
            data_start_addr   = $urandom;
            wb_addr           = $urandom;
            #1;
            exp_busy  = (m_q.size() != 0);
            exp_ready = !exp_busy && (m_size < 127) && !clear;
            exp_wr    = exp_busy && !fifo_full;
            chk("rnd_ready", d1_ready, exp_ready);
            chk("rnd_wr_en", d1_wr_en, exp_wr);
            chk("rnd_busy", d1_busy, exp_busy);
            chk("rnd_size", d1_size, 32'(m_size));
            chk("rnd_err", d1_err, m_err);
            if (exp_busy) chk("rnd_din", d1_din, m_q[0]);
            else          chk("rnd_din_idle", d1_din, 32'h0);
            if (exp_wr) begin
                m_q.delete(0);
                if (m_q.size() == 0) m_size++;
            end else if (!exp_busy) begin
                if (clear) begin
                    m_size = 0;
                    m_err  = 1'b0;
                end else if (cmd_valid && exp_ready) begin
                    if (op_type >= 3'd1 && op_type <= 3'd5) begin
                        w0 = (32'(stride_2) << 16) + (32'(stride_1) << 8) + (32'(padding) << 3) + 32'(op_type);
                        m_q.push_back(w0);
                        m_q.push_back((32'(och_size) << 16) + 32'(ich_size));
                        m_q.push_back((32'(okn_size) << 16) + 32'(ikn_size));
                        m_q.push_back(weight_start_addr);
                        m_q.push_back(data_start_addr);
                        m_q.push_back(wb_addr);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
